// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: gathers WIDTH framed bits into a word behind a
// one-word valid/ready holding register, with sticky overrun and framing-error flags.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_nxt;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             word_done, ferr_set, hold_free;

  assign sh_nxt = MSB_FIRST ? {sh_q[WIDTH-2:0], sdi} : {sdi, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    word_done = 1'b0;
    ferr_set  = 1'b0;
    if (sdi_valid) begin
      case (state_q)
        IDLE: begin
          if (sof) begin
            sh_d    = sh_nxt;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sh_d = sh_nxt;
          if (sof) begin
            // A new sof restarts framing on this very bit.
            cnt_d    = CW'(1);
            ferr_set = 1'b1;
          end else if (cnt_q == LAST) begin
            cnt_d     = '0;
            state_d   = IDLE;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_free  = !dout_vld_q || dout_ready;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    if (word_done && hold_free) begin
      dout_d     = sh_nxt;
      dout_vld_d = 1'b1;
    end else if (dout_vld_q && dout_ready) begin
      dout_vld_d = 1'b0;
    end
    // Set events take priority over a same-cycle clear.
    ovr_d  = (word_done && !hold_free) ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
    ferr_d = ferr_set ? 1'b1 : (clr_err ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_vld_q;
  assign busy       = (state_q == SHIFT);
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus and are
// compared each cycle against a queue-based frame model.
module tb_sipo_deser;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic sdi, sdi_valid, sof, dout_ready, clr_err;
  logic [W-1:0] dout_m, dout_l;
  logic vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l, fe_m, fe_l;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_valid(sdi_valid), .sof(sof),
    .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready), .busy(busy_m),
    .overrun(ovr_m), .frame_err(fe_m), .clr_err(clr_err));

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_valid(sdi_valid), .sof(sof),
    .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready), .busy(busy_l),
    .overrun(ovr_l), .frame_err(fe_l), .clr_err(clr_err));

  int nvec = 0;
  int nerr = 0;

  // Reference model: bits of the frame in progress, plus holding-register view.
  logic     fq[$];
  logic [W-1:0] e_dm, e_dl;
  logic     e_vld, e_ovr, e_fe;

  function automatic logic [2*W+8:0] act();
    return {dout_m, dout_l, vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l, fe_m, fe_l, 1'b0};
  endfunction

  function automatic logic [2*W+8:0] exp_v();
    logic bz;
    bz = (fq.size() > 0);
    return {e_dm, e_dl, e_vld, e_vld, bz, bz, e_ovr, e_ovr, e_fe, e_fe, 1'b0};
  endfunction

  task automatic model_reset();
    fq.delete();
    e_dm = '0; e_dl = '0; e_vld = 1'b0; e_ovr = 1'b0; e_fe = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic step(input logic b, input logic v, input logic s, input logic r, input logic c);
    logic done, set_ov, set_fe;
    logic [W-1:0] wm, wl;
    sdi = b; sdi_valid = v; sof = s; dout_ready = r; clr_err = c;
    done = 1'b0; set_ov = 1'b0; set_fe = 1'b0; wm = '0; wl = '0;
    if (v) begin
      if (s) begin
        if (fq.size() > 0) set_fe = 1'b1;
        fq.delete();
        fq.push_back(b);
      end else if (fq.size() > 0) begin
        fq.push_back(b);
        if (fq.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = fq[i];
            wl[i]     = fq[i];
          end
          fq.delete();
        end
      end
    end
    if (done && (!e_vld || r)) begin
      e_vld = 1'b1; e_dm = wm; e_dl = wl;
    end else begin
      if (done) set_ov = 1'b1;
      if (e_vld && r) e_vld = 1'b0;
    end
    e_ovr = set_ov ? 1'b1 : (c ? 1'b0 : e_ovr);
    e_fe  = set_fe ? 1'b1 : (c ? 1'b0 : e_fe);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sdi = 0; sdi_valid = 0; sof = 0; dout_ready = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (act() !== '0) begin
      nerr++; $display("FAIL reset outputs got %h exp 0", act());
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step(bits[3-i], 1'b1, i == 0, 1'b1, 1'b0);
      nvec++;
      if (act() !== exp_v()) begin nerr++; $display("FAIL basic_cyc%0d got %h exp %h", i, act(), exp_v()); end
    end
    nvec++;
    if (dout_m !== 4'hB || vld_m !== 1'b1) begin
      nerr++; $display("FAIL basic_word got %h/%b exp b/1", dout_m, vld_m);
    end
    step(0, 0, 0, 1, 0);
    nvec++;
    if (vld_m !== 1'b0) begin nerr++; $display("FAIL basic_onecycle got vld %b exp 0", vld_m); end
  endtask

  task automatic test_gapped();
    logic [3:0] bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step(bits[3-i], 1'b1, i == 0, 1'b1, 1'b0);
      if (i < 3) begin
        repeat (1 + (i % 3)) begin
          step($urandom_range(0, 1), 1'b0, $urandom_range(0, 1), 1'b1, 1'b0);
          nvec++;
          if (busy_m !== 1'b1 || act() !== exp_v()) begin
            nerr++; $display("FAIL gap_busy got %h exp %h", act(), exp_v());
          end
        end
      end
    end
    nvec++;
    if (dout_m !== 4'hB || vld_m !== 1'b1) begin
      nerr++; $display("FAIL gap_word got %h/%b exp b/1", dout_m, vld_m);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic send(input logic [3:0] w, input logic r_last);
    for (int i = 0; i < 4; i++) step(w[3-i], 1'b1, i == 0, (i == 3) ? r_last : 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    send(4'hA, 1'b0);
    send(4'h5, 1'b0);
    nvec++;
    if (dout_m !== 4'hA || vld_m !== 1'b1 || ovr_m !== 1'b1 || act() !== exp_v()) begin
      nerr++; $display("FAIL bp_hold got %h/%b ovr %b exp a/1 ovr 1", dout_m, vld_m, ovr_m);
    end
    step(0, 0, 0, 1, 0);
    nvec++;
    if (vld_m !== 1'b0 || dout_m !== 4'hA) begin
      nerr++; $display("FAIL bp_drain got %h/%b exp a/0", dout_m, vld_m);
    end
    step(0, 0, 0, 0, 1);
    nvec++;
    if (ovr_m !== 1'b0) begin nerr++; $display("FAIL bp_clr got ovr %b exp 0", ovr_m); end
  endtask

  task automatic test_drain_load();
    send(4'hA, 1'b0);
    send(4'h5, 1'b1);
    nvec++;
    if (dout_m !== 4'h5 || vld_m !== 1'b1 || ovr_m !== 1'b0 || act() !== exp_v()) begin
      nerr++; $display("FAIL drainload got %h/%b ovr %b exp 5/1 ovr 0", dout_m, vld_m, ovr_m);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_frame_err();
    logic [5:0] bits = 6'b110110;
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1, (i == 0) || (i == 2), 1'b1, 1'b0);
      nvec++;
      if (act() !== exp_v() || (i < 5 && vld_m !== 1'b0)) begin
        nerr++; $display("FAIL ferr_cyc%0d got %h exp %h", i, act(), exp_v());
      end
    end
    nvec++;
    if (fe_m !== 1'b1 || dout_m !== 4'h6 || vld_m !== 1'b1) begin
      nerr++; $display("FAIL ferr_word got %h/%b fe %b exp 6/1 fe 1", dout_m, vld_m, fe_m);
    end
    step(0, 0, 0, 1, 1);
    nvec++;
    if (fe_m !== 1'b0) begin nerr++; $display("FAIL ferr_clr got %b exp 0", fe_m); end
  endtask

  task automatic test_reset_order();
    step(1, 1, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (act() !== '0) begin nerr++; $display("FAIL midreset got %h exp 0", act()); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(4'hC, 1'b1);
    nvec++;
    if (dout_m !== 4'hC || vld_m !== 1'b1 || act() !== exp_v()) begin
      nerr++; $display("FAIL postreset got %h/%b exp c/1", dout_m, vld_m);
    end
    send(4'b1000, 1'b1);
    nvec++;
    if (dout_l !== 4'h1 || dout_m !== 4'h8) begin
      nerr++; $display("FAIL lsbfirst got lsb %h msb %h exp 1/8", dout_l, dout_m);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      nvec++;
      if (act() !== exp_v()) begin
        nerr++; $display("FAIL random_cyc%0d got %h exp %h", n, act(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_drain_load();
    test_frame_err();
    test_reset_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
